cavlc_residual_ctrl: RTL
========================

// Module: cavlc_residual_ctrl
// PURPOSE
// Sequencer for one CAVLC residual-block decode. Steps the shared bit window through coeff_token
// (CoeffTokenTable lookup), trailing-one signs, levels, total_zeros and run_before.
// Drives the level/zeros/run decoders over req/ack and writes placed coefficients to block storage.
// PARAMETERS
// LEVEL_W   16  signed coefficient width
// MAX_COEFF 16  level store depth / max MaxNumCoeff
// PORTS
// Clk           in  1  clock
// Reset         in  1  synchronous active-high reset
// Start         in  1  begin block; sampled in IDLE only
// MaxNumCoeff   in  5  4/15/16, latched on Start
// BitsValid     in  1  window holds >=32 valid bits
// WinTop        in  3  top 3 window bits (T1 signs)
// Consume/ConsumeLen out 1/6  advance window ConsumeLen bits, 1-cycle pulse
// CtReq         out 1  table lookup strobe; result valid next cycle
// TotalCoeff/TrailingOnes/CtLen in 5/2/5  table result
// LevelReq/LevelAck  out/in 1  level decoder handshake
// LevelSuffixLen out 3  current suffixLength; LevelAdj out 1: +1 magnitude adjust this level
// LevelVal/LevelLen  in LEVEL_W/6  decoded level, bits used
// ZerosReq/ZerosAck  out/in 1; TotalZeros/ZerosLen in 5/5
// RunReq/RunAck      out/in 1; ZerosLeft out 5; RunBefore/RunLen in 4/4
// BlkStart      out 1  pulse on Start accept (consumer zeroes block)
// CoeffWrEn/CoeffIdx/CoeffVal out 1/4/LEVEL_W  coefficient write
// Busy/Done/Error out 1  Done 1-cycle pulse; Error sticky until next Start
// BEHAVIOUR
// - Reset: state IDLE; every output 0; outstanding Req dropped at next edge, no Done.
// - Start ignored while Busy.
// - Req held high until Ack, deasserted the cycle after Ack; Ack cycle pulses Consume (len from decoder).
// - After any Consume, one idle cycle before the next window-dependent action. Window use also waits on BitsValid.
// - States:
//   - IDLE: Start -> CT (pulse BlkStart).
//   - CT: wait BitsValid, pulse CtReq -> CTW.
//   - CTW: latch TC/T1, Consume CtLen.
//     - TC==0 -> DONE.
//     - TC>MaxNumCoeff -> Error, DONE.
//     - T1>0 -> T1S; else LVL.
//   - T1S: bit WinTop[2-i] 0 -> +1, 1 -> -1 into lvl[i], i<T1; Consume T1.
//     - TC>T1 -> LVL; else TZ.
//   - LVL: one req per lvl[T1..TC-1].
//     - suffixLength init = (TC>10 && T1<3).
//     - LevelAdj=1 on first level iff T1<3.
//     - After each level: suffix==0 -> 1; then if |lvl|>(3<<(suffix-1)) && suffix<6, suffix++.
//   - TZ: TC==MaxNumCoeff -> TotalZeros=0, skip req.
//     - TC+TotalZeros>MaxNumCoeff -> Error, DONE.
//     - pos=TC+TotalZeros-1; zl=TotalZeros -> RUN.
//   - RUN: for i=0..TC-1:
//     - write lvl[i] at pos.
//     - if i<TC-1 && zl>0: RunReq with ZerosLeft=zl; RunBefore>zl -> Error, DONE; else pos-=Run+1, zl-=Run.
//     - else pos-=1 (no req).
//     - One CoeffWrEn per level; idx strictly decreasing.
//   - DONE: Done=1 one cycle, Busy=0 next -> IDLE.
// - Busy=1 in all states except IDLE.
// - Arithmetic: pos/zl 5-bit unsigned, never negative by error checks; lvl[] holds LevelVal unmodified.
// STRUCTURE
// - cavlc_pkg: state enum, MAX_COEFF, LEVEL_W, LEN_W=6, IDX_W=4 constants.
// - Sub-module cavlc_suffix_len: suffixLength init/update register + LevelAdj.
// - Level store: MAX_COEFF x LEVEL_W reg array.
// TESTING
// - Table TC=0,CtLen=1 -> Consume 1, Done, no CoeffWrEn, Error=0.
// - TC=5,T1=3, WinTop=001, levels -1,3, TotalZeros=4, runs 1,0,2,0 -> writes (8,+1)(6,+1)(5,-1)(2,-1)(1,+3); LevelSuffixLen 0 then 1.
// - TC=4,T1=0,TotalZeros=0 -> no RunReq, writes idx 3,2,1,0.
// - MaxNumCoeff=16,TC=16 -> no ZerosReq/RunReq, writes idx 15..0.
// - TC=4,TotalZeros=13,Max=16 -> Error=1, Done, no writes.
// - Reset while LevelReq=1 -> next cycle LevelReq=0, Busy=0, Done never pulses.

Source files
------------

// File: rtl/cavlc_residual_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_pkg
// Purpose  : Shared constants and FSM state encoding for the CAVLC residual
//            block sequencer.
// Contents : LEVEL_W, MAX_COEFF, LEN_W, IDX_W, state_e
// Revision : 1.0  initial release
// ============================================================================
package cavlc_pkg;

  localparam int LEVEL_W   = 16;  // signed coefficient width
  localparam int MAX_COEFF = 16;  // level store depth
  localparam int LEN_W     = 6;   // window consume length width
  localparam int IDX_W     = 4;   // coefficient index width

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_CT   = 4'd1,  // wait for window, strobe the coeff_token lookup
    ST_CTW  = 4'd2,  // lookup result valid: latch TC/T1, consume
    ST_T1S  = 4'd3,  // trailing-one sign bits
    ST_LVL  = 4'd4,  // remaining levels via level decoder
    ST_TZ   = 4'd5,  // total_zeros
    ST_RUN  = 4'd6,  // write one coefficient
    ST_RUNW = 4'd7,  // run_before request for the coefficient just written
    ST_DONE = 4'd8
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cavlc_residual_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_residual_ctrl_if
// Purpose  : Bundles the bit-window, decoder handshakes and coefficient
//            write bus of the CAVLC residual sequencer.
// Modports : master - the sequencer (drives Consume, *Req, Coeff*, status)
//            slave  - the surrounding datapath / decoders / block store
// Revision : 1.0  initial release
// ============================================================================
interface cavlc_residual_ctrl_if #(
  parameter int LEVEL_W = 16
) ();
  import cavlc_pkg::*;

  // control and window
  logic               Start;
  logic [4:0]         MaxNumCoeff;
  logic               BitsValid;
  logic [2:0]         WinTop;
  logic               Consume;
  logic [LEN_W-1:0]   ConsumeLen;
  // coeff_token table
  logic               CtReq;
  logic [4:0]         TotalCoeff;
  logic [1:0]         TrailingOnes;
  logic [4:0]         CtLen;
  // level decoder
  logic               LevelReq;
  logic               LevelAck;
  logic [2:0]         LevelSuffixLen;
  logic               LevelAdj;
  logic [LEVEL_W-1:0] LevelVal;
  logic [5:0]         LevelLen;
  // total_zeros decoder
  logic               ZerosReq;
  logic               ZerosAck;
  logic [4:0]         TotalZeros;
  logic [4:0]         ZerosLen;
  // run_before decoder
  logic               RunReq;
  logic               RunAck;
  logic [4:0]         ZerosLeft;
  logic [3:0]         RunBefore;
  logic [3:0]         RunLen;
  // block store and status
  logic               BlkStart;
  logic               CoeffWrEn;
  logic [IDX_W-1:0]   CoeffIdx;
  logic [LEVEL_W-1:0] CoeffVal;
  logic               Busy;
  logic               Done;
  logic               Error;

  modport master (
    input  Start, MaxNumCoeff, BitsValid, WinTop,
    input  TotalCoeff, TrailingOnes, CtLen,
    input  LevelAck, LevelVal, LevelLen,
    input  ZerosAck, TotalZeros, ZerosLen,
    input  RunAck, RunBefore, RunLen,
    output Consume, ConsumeLen, CtReq,
    output LevelReq, LevelSuffixLen, LevelAdj,
    output ZerosReq, RunReq, ZerosLeft,
    output BlkStart, CoeffWrEn, CoeffIdx, CoeffVal,
    output Busy, Done, Error
  );

  modport slave (
    output Start, MaxNumCoeff, BitsValid, WinTop,
    output TotalCoeff, TrailingOnes, CtLen,
    output LevelAck, LevelVal, LevelLen,
    output ZerosAck, TotalZeros, ZerosLen,
    output RunAck, RunBefore, RunLen,
    input  Consume, ConsumeLen, CtReq,
    input  LevelReq, LevelSuffixLen, LevelAdj,
    input  ZerosReq, RunReq, ZerosLeft,
    input  BlkStart, CoeffWrEn, CoeffIdx, CoeffVal,
    input  Busy, Done, Error
  );

endinterface
`default_nettype wire

// File: rtl/cavlc_residual_ctrl_suffix_len.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_suffix_len
// Purpose  : Tracks the level-prefix suffixLength across the levels of one
//            block and flags the +1 magnitude adjustment for the first level.
// Ports    : clk, rst          clock, synchronous active-high reset
//            init, tc, t1      load initial value from TotalCoeff/TrailingOnes
//            upd, lvl          advance after a decoded level
//            suffix_len        current suffixLength (0..6)
//            level_adj         first level of block with fewer than 3 T1s
// Revision : 1.0  initial release
// ============================================================================
module cavlc_suffix_len #(
  parameter int LEVEL_W = 16
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               init,
  input  wire logic [4:0]         tc,
  input  wire logic [1:0]         t1,
  input  wire logic               upd,
  input  wire logic [LEVEL_W-1:0] lvl,
  output logic      [2:0]         suffix_len,
  output logic                    level_adj
);

  logic [2:0]         suffix_q, suffix_d;
  logic               first_q, first_d;
  logic               t1_lt3_q, t1_lt3_d;
  logic [2:0]         s_bump;
  logic [LEVEL_W-1:0] abs_lvl;
  logic [LEVEL_W-1:0] thresh;

  always_comb begin
    suffix_d = suffix_q;
    first_d  = first_q;
    t1_lt3_d = t1_lt3_q;
    // a zero suffixLength is promoted to 1 before the escalation test
    s_bump   = (suffix_q == 3'd0) ? 3'd1 : suffix_q;
    abs_lvl  = lvl[LEVEL_W-1] ? (~lvl + LEVEL_W'(1)) : lvl;
    thresh   = LEVEL_W'(3) << (s_bump - 3'd1);
    if (init) begin
      suffix_d = ((tc > 5'd10) && (t1 != 2'd3)) ? 3'd1 : 3'd0;
      first_d  = 1'b1;
      t1_lt3_d = (t1 != 2'd3);
    end else if (upd) begin
      suffix_d = ((abs_lvl > thresh) && (s_bump < 3'd6)) ? s_bump + 3'd1 : s_bump;
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      suffix_q <= 3'd0;
      first_q  <= 1'b0;
      t1_lt3_q <= 1'b0;
    end else begin
      suffix_q <= suffix_d;
      first_q  <= first_d;
      t1_lt3_q <= t1_lt3_d;
    end
  end

  assign suffix_len = suffix_q;
  assign level_adj  = first_q & t1_lt3_q;

endmodule
`default_nettype wire

// File: rtl/cavlc_residual_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cavlc_residual_ctrl
// Purpose  : Sequences one CAVLC residual-block decode: coeff_token lookup,
//            trailing-one signs, levels, total_zeros and run_before, and
//            writes the placed coefficients to block storage.
// Ports    : Clk, Reset  clock, synchronous active-high reset
//            bus         cavlc_residual_ctrl_if.master (window, decoder
//                        req/ack handshakes, coefficient writes, status)
// Revision : 1.0  initial release
// ============================================================================
module cavlc_residual_ctrl #(
  parameter int LEVEL_W   = cavlc_pkg::LEVEL_W,
  parameter int MAX_COEFF = cavlc_pkg::MAX_COEFF
) (
  input  wire logic              Clk,
  input  wire logic              Reset,
  cavlc_residual_ctrl_if.master  bus
);
  import cavlc_pkg::*;

  localparam logic [LEVEL_W-1:0] POS_ONE = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] NEG_ONE = '1;

  state_e            state_q, state_d;
  logic [4:0]        max_q, max_d;
  logic [4:0]        tc_q, tc_d;
  logic [1:0]        t1_q, t1_d;
  logic [4:0]        cnt_q, cnt_d;   // level index being stored / written
  logic [4:0]        pos_q, pos_d;   // next coefficient position
  logic [4:0]        zl_q, zl_d;     // zeros left to place
  logic              err_q, err_d;
  logic              gap_q, gap_d;   // window settles for one cycle after a consume
  logic              lreq_q, lreq_d;
  logic              zreq_q, zreq_d;
  logic              rreq_q, rreq_d;

  logic [LEVEL_W-1:0] lvl_q [MAX_COEFF];

  logic              consume;
  logic [LEN_W-1:0]  consume_len;
  logic              ct_req, blk_start, done;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [LEVEL_W-1:0] wr_val;
  logic              t1_wr, lvl_wr, sfx_init, sfx_upd;
  logic              win_ok;
  logic [5:0]        tz_sum;
  logic [2:0]        sfx_len;
  logic              sfx_adj;

  assign win_ok = bus.BitsValid & ~gap_q;
  assign tz_sum = {1'b0, tc_q} + {1'b0, bus.TotalZeros};
  assign gap_d  = consume;

  always_comb begin
    state_d     = state_q;
    max_d       = max_q;
    tc_d        = tc_q;
    t1_d        = t1_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    zl_d        = zl_q;
    err_d       = err_q;
    lreq_d      = lreq_q;
    zreq_d      = zreq_q;
    rreq_d      = rreq_q;
    consume     = 1'b0;
    consume_len = '0;
    ct_req      = 1'b0;
    blk_start   = 1'b0;
    done        = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = '0;
    wr_val      = '0;
    t1_wr       = 1'b0;
    lvl_wr      = 1'b0;
    sfx_init    = 1'b0;
    sfx_upd     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          blk_start = 1'b1;
          max_d     = bus.MaxNumCoeff;
          err_d     = 1'b0;
          state_d   = ST_CT;
        end
      end

      ST_CT: begin
        if (win_ok) begin
          ct_req  = 1'b1;
          state_d = ST_CTW;
        end
      end

      ST_CTW: begin
        consume     = 1'b1;
        consume_len = {1'b0, bus.CtLen};
        tc_d        = bus.TotalCoeff;
        t1_d        = bus.TrailingOnes;
        cnt_d       = 5'd0;
        sfx_init    = 1'b1;
        if (bus.TotalCoeff == 5'd0) begin
          state_d = ST_DONE;
        end else if (bus.TotalCoeff > max_q) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (bus.TrailingOnes != 2'd0) begin
          state_d = ST_T1S;
        end else begin
          state_d = ST_LVL;
        end
      end

      ST_T1S: begin
        if (win_ok) begin
          t1_wr       = 1'b1;
          consume     = 1'b1;
          consume_len = {4'd0, t1_q};
          if (tc_q > {3'd0, t1_q}) begin
            cnt_d   = {3'd0, t1_q};
            state_d = ST_LVL;
          end else begin
            state_d = ST_TZ;
          end
        end
      end

      ST_LVL: begin
        if (lreq_q) begin
          if (bus.LevelAck) begin
            consume     = 1'b1;
            consume_len = bus.LevelLen;
            lreq_d      = 1'b0;
            lvl_wr      = 1'b1;
            sfx_upd     = 1'b1;
            cnt_d       = cnt_q + 5'd1;
            if (cnt_q + 5'd1 == tc_q) state_d = ST_TZ;
          end
        end else if (win_ok) begin
          lreq_d = 1'b1;
        end
      end

      ST_TZ: begin
        if (tc_q == max_q) begin
          // block is full: no zeros to place, no total_zeros in the stream
          pos_d   = tc_q - 5'd1;
          zl_d    = 5'd0;
          cnt_d   = 5'd0;
          state_d = ST_RUN;
        end else if (zreq_q) begin
          if (bus.ZerosAck) begin
            consume     = 1'b1;
            consume_len = {1'b0, bus.ZerosLen};
            zreq_d      = 1'b0;
            if (tz_sum > {1'b0, max_q}) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              pos_d   = 5'(tz_sum - 6'd1);
              zl_d    = bus.TotalZeros;
              cnt_d   = 5'd0;
              state_d = ST_RUN;
            end
          end
        end else if (win_ok) begin
          zreq_d = 1'b1;
        end
      end

      ST_RUN: begin
        wr_en  = 1'b1;
        wr_idx = IDX_W'(pos_q);
        wr_val = lvl_q[IDX_W'(cnt_q)];
        if (cnt_q == tc_q - 5'd1) begin
          state_d = ST_DONE;
        end else if (zl_q != 5'd0) begin
          state_d = ST_RUNW;
        end else begin
          pos_d = pos_q - 5'd1;
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_RUNW: begin
        if (rreq_q) begin
          if (bus.RunAck) begin
            consume     = 1'b1;
            consume_len = {2'd0, bus.RunLen};
            rreq_d      = 1'b0;
            if ({1'b0, bus.RunBefore} > zl_q) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              pos_d   = pos_q - {1'b0, bus.RunBefore} - 5'd1;
              zl_d    = zl_q - {1'b0, bus.RunBefore};
              cnt_d   = cnt_q + 5'd1;
              state_d = ST_RUN;
            end
          end
        end else if (win_ok) begin
          rreq_d = 1'b1;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      max_q   <= 5'd0;
      tc_q    <= 5'd0;
      t1_q    <= 2'd0;
      cnt_q   <= 5'd0;
      pos_q   <= 5'd0;
      zl_q    <= 5'd0;
      err_q   <= 1'b0;
      gap_q   <= 1'b0;
      lreq_q  <= 1'b0;
      zreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      tc_q    <= tc_d;
      t1_q    <= t1_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      zl_q    <= zl_d;
      err_q   <= err_d;
      gap_q   <= gap_d;
      lreq_q  <= lreq_d;
      zreq_q  <= zreq_d;
      rreq_q  <= rreq_d;
    end
  end

  // Level store: T1 signs fill the low entries (WinTop[2] is the first T1),
  // decoded levels follow in bitstream order.
  always_ff @(posedge Clk) begin
    if (t1_wr) begin
      for (int k = 0; k < 3; k++) begin
        if (k < int'(t1_q)) lvl_q[k] <= bus.WinTop[2-k] ? NEG_ONE : POS_ONE;
      end
    end
    if (lvl_wr) lvl_q[IDX_W'(cnt_q)] <= bus.LevelVal;
  end

  cavlc_suffix_len #(
    .LEVEL_W (LEVEL_W)
  ) u_suffix_len (
    .clk        (Clk),
    .rst        (Reset),
    .init       (sfx_init),
    .tc         (bus.TotalCoeff),
    .t1         (bus.TrailingOnes),
    .upd        (sfx_upd),
    .lvl        (bus.LevelVal),
    .suffix_len (sfx_len),
    .level_adj  (sfx_adj)
  );

  assign bus.Consume        = consume;
  assign bus.ConsumeLen     = consume_len;
  assign bus.CtReq          = ct_req;
  assign bus.LevelReq       = lreq_q;
  assign bus.LevelSuffixLen = sfx_len;
  assign bus.LevelAdj       = lreq_q & sfx_adj;
  assign bus.ZerosReq       = zreq_q;
  assign bus.RunReq         = rreq_q;
  assign bus.ZerosLeft      = zl_q;
  assign bus.BlkStart       = blk_start;
  assign bus.CoeffWrEn      = wr_en;
  assign bus.CoeffIdx       = wr_idx;
  assign bus.CoeffVal       = wr_val;
  assign bus.Busy           = (state_q != ST_IDLE);
  assign bus.Done           = done;
  assign bus.Error          = err_q;

endmodule
`default_nettype wire
